ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM with registered read return.
// Optional burst lock is enabled by defining RAM_ARBITER_BURST_LOCK_EN.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_MAX  = 16
) (
    input  logic                  RAM_ARBITER_Clk,
    input  logic                  RAM_ARBITER_Reset_InLow,
    input  logic                  RAM_ARBITER_Req0,
    input  logic                  RAM_ARBITER_Req1,
    input  logic                  RAM_ARBITER_We0,
    input  logic                  RAM_ARBITER_We1,
    input  logic [ADDR_WIDTH-1:0] RAM_ARBITER_Addr0,
    input  logic [ADDR_WIDTH-1:0] RAM_ARBITER_Addr1,
    input  logic [DATA_WIDTH-1:0] RAM_ARBITER_Wdata0,
    input  logic [DATA_WIDTH-1:0] RAM_ARBITER_Wdata1,
    output logic                  RAM_ARBITER_Gnt0,
    output logic                  RAM_ARBITER_Gnt1,
    output logic                  RAM_ARBITER_Rvalid0,
    output logic                  RAM_ARBITER_Rvalid1,
    output logic [DATA_WIDTH-1:0] RAM_ARBITER_Rdata,
    output logic                  RAM_ARBITER_Ram_We,
    output logic                  RAM_ARBITER_Ram_Oe,
    output logic [ADDR_WIDTH-1:0] RAM_ARBITER_Ram_Address,
    output logic [DATA_WIDTH-1:0] RAM_ARBITER_Ram_Data_In,
    input  logic [DATA_WIDTH-1:0] RAM_ARBITER_Ram_Data_Out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    if (BURST_MAX < 1) begin : g_burst_max_check
        $error("ram_arbiter: BURST_MAX must be at least 1");
    end

    state_t state, state_next;
    logic   rr_ptr;
    logic   tag_valid;
    logic   tag_owner;
    logic   gnt0;
    logic   gnt1;
    logic   keep0;
    logic   keep1;

`ifdef RAM_ARBITER_BURST_LOCK_EN
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(BURST_MAX);

    logic [CNT_W-1:0] burst_cnt, burst_cnt_next;

    // Owner keeps the grant under contention until it has used up its burst.
    assign keep0 = (burst_cnt < BURST_LIMIT);
    assign keep1 = (burst_cnt < BURST_LIMIT);

    always_comb begin
        burst_cnt_next = '0;
        if ((gnt0 && state == OWN0) || (gnt1 && state == OWN1)) begin
            burst_cnt_next = (burst_cnt == BURST_LIMIT) ? burst_cnt : burst_cnt + 1'b1;
        end else if (gnt0 || gnt1) begin
            burst_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge RAM_ARBITER_Clk or negedge RAM_ARBITER_Reset_InLow) begin
        if (!RAM_ARBITER_Reset_InLow) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_cnt_next;
        end
    end
`else
    assign keep0 = 1'b0;
    assign keep1 = 1'b0;
`endif

    // Grants are gated by reset so nothing is issued while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (RAM_ARBITER_Reset_InLow) begin
            if (RAM_ARBITER_Req0 && !RAM_ARBITER_Req1) begin
                gnt0 = 1'b1;
            end else if (RAM_ARBITER_Req1 && !RAM_ARBITER_Req0) begin
                gnt1 = 1'b1;
            end else if (RAM_ARBITER_Req0 && RAM_ARBITER_Req1) begin
                case (state)
                    IDLE: begin
                        gnt0 = !rr_ptr;
                        gnt1 = rr_ptr;
                    end
                    OWN0: begin
                        gnt0 = keep0;
                        gnt1 = !keep0;
                    end
                    OWN1: begin
                        gnt0 = !keep1;
                        gnt1 = keep1;
                    end
                    default: begin
                        gnt0 = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_next = IDLE;
        if (gnt0) begin
            state_next = OWN0;
        end else if (gnt1) begin
            state_next = OWN1;
        end
    end

    always_ff @(posedge RAM_ARBITER_Clk or negedge RAM_ARBITER_Reset_InLow) begin
        if (!RAM_ARBITER_Reset_InLow) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            tag_valid <= 1'b0;
            tag_owner <= 1'b0;
        end else begin
            state     <= state_next;
            if (gnt0) begin
                rr_ptr <= 1'b1;
            end else if (gnt1) begin
                rr_ptr <= 1'b0;
            end
            tag_valid <= (gnt0 && !RAM_ARBITER_We0) || (gnt1 && !RAM_ARBITER_We1);
            tag_owner <= gnt1;
        end
    end

    always_comb begin
        RAM_ARBITER_Ram_We      = 1'b0;
        RAM_ARBITER_Ram_Address = '0;
        RAM_ARBITER_Ram_Data_In = '0;
        if (gnt0) begin
            RAM_ARBITER_Ram_We      = RAM_ARBITER_We0;
            RAM_ARBITER_Ram_Address = RAM_ARBITER_Addr0;
            RAM_ARBITER_Ram_Data_In = RAM_ARBITER_Wdata0;
        end else if (gnt1) begin
            RAM_ARBITER_Ram_We      = RAM_ARBITER_We1;
            RAM_ARBITER_Ram_Address = RAM_ARBITER_Addr1;
            RAM_ARBITER_Ram_Data_In = RAM_ARBITER_Wdata1;
        end
    end

    assign RAM_ARBITER_Gnt0    = gnt0;
    assign RAM_ARBITER_Gnt1    = gnt1;
    assign RAM_ARBITER_Ram_Oe  = tag_valid;
    assign RAM_ARBITER_Rvalid0 = tag_valid && !tag_owner;
    assign RAM_ARBITER_Rvalid1 = tag_valid && tag_owner;
    assign RAM_ARBITER_Rdata   = tag_valid ? RAM_ARBITER_Ram_Data_Out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a registered-read RAM model.
// Define RAM_ARBITER_BURST_LOCK_EN to exercise the burst-lock build.
module tb_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wd0, wd1;
    logic          gnt0, gnt1, rv0, rv1, ram_we, ram_oe;
    logic [DW-1:0] rdata, ram_din, ram_q;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [0:1023];
    logic          mem_loaded = 1'b0;

    logic [44:0] gnt_q[$];
    logic [34:0] rd_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(4)) dut (
        .RAM_ARBITER_Clk         (clk),
        .RAM_ARBITER_Reset_InLow (rst_n),
        .RAM_ARBITER_Req0        (req0),
        .RAM_ARBITER_Req1        (req1),
        .RAM_ARBITER_We0         (we0),
        .RAM_ARBITER_We1         (we1),
        .RAM_ARBITER_Addr0       (addr0),
        .RAM_ARBITER_Addr1       (addr1),
        .RAM_ARBITER_Wdata0      (wd0),
        .RAM_ARBITER_Wdata1      (wd1),
        .RAM_ARBITER_Gnt0        (gnt0),
        .RAM_ARBITER_Gnt1        (gnt1),
        .RAM_ARBITER_Rvalid0     (rv0),
        .RAM_ARBITER_Rvalid1     (rv1),
        .RAM_ARBITER_Rdata       (rdata),
        .RAM_ARBITER_Ram_We      (ram_we),
        .RAM_ARBITER_Ram_Oe      (ram_oe),
        .RAM_ARBITER_Ram_Address (ram_addr),
        .RAM_ARBITER_Ram_Data_In (ram_din),
        .RAM_ARBITER_Ram_Data_Out(ram_q)
    );

    // RAM: word i holds A5A5_0000+i, except word 5 = DEADBEEF; 1-cycle read.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= (i == 5) ? 32'hDEADBEEF : 32'hA5A5_0000 + i;
            end
            mem_loaded <= 1'b1;
        end else begin
            ram_q <= mem[ram_addr];
            if (ram_we) begin
                mem[ram_addr] <= ram_din;
            end
        end
    end

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1) begin
                if (gnt_q.size() == 0) chk("gnt_unexpected", {gnt0, gnt1}, 0);
                else chk("gnt_bus", {gnt0, gnt1, ram_we, ram_addr, ram_din}, gnt_q.pop_front());
            end else begin
                chk("idle_bus", {ram_we, ram_addr, ram_din}, 0);
            end
            if (rv0 || rv1 || ram_oe) begin
                if (rd_q.size() == 0) chk("rvalid_unexpected", {rv0, rv1, ram_oe}, 0);
                else chk("read_return", {rv0, rv1, ram_oe, rdata}, rd_q.pop_front());
            end else begin
                chk("rdata_idle", rdata, 0);
            end
        end
    end

    task automatic cyc(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input int g, input logic [DW-1:0] erd, input bit push_rd = 1'b1);
        req0 = r0; we0 = w0; addr0 = a0; wd0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wd1 = d1;
        if (g == 0) begin
            gnt_q.push_back({2'b10, w0, a0, d0});
            if (!w0 && push_rd) rd_q.push_back({3'b101, erd});
        end else if (g == 1) begin
            gnt_q.push_back({2'b01, w1, a1, d1});
            if (!w1 && push_rd) rd_q.push_back({3'b011, erd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, '0, '0, 0, 0, '0, '0, -1, '0);
    endtask

    // Both request reads: requester 0 at 0x010, requester 1 at 0x020.
    task automatic both(input int g);
        cyc(1, 0, 10'h010, '0, 1, 0, 10'h020, '0, g, (g == 0) ? 32'hA5A5_0010 : 32'hA5A5_0020);
    endtask

`ifdef RAM_ARBITER_BURST_LOCK_EN
    int cont_exp[$] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int rr_exp[$]   = '{1, 1};
`else
    int cont_exp[$] = '{0, 1, 0, 1, 0, 1};
    int rr_exp[$]   = '{1, 0};
`endif

    initial begin
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b0;
        addr0 = 10'h155; addr1 = 10'h2AA; wd0 = 32'hFFFF_FFFF; wd1 = 32'h1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ctrl", {gnt0, gnt1, rv0, rv1, ram_we, ram_oe}, 0);
        chk("rst_data", {rdata, ram_addr, ram_din}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (cont_exp[i]) both(cont_exp[i]);
        idle();

        cyc(1, 0, 10'h005, '0, 0, 0, '0, '0, 0, 32'hDEADBEEF);
        idle();

        cyc(0, 0, '0, '0, 1, 1, 10'h3FF, 32'h1234_5678, 1, '0);
        idle();
        cyc(1, 0, 10'h3FF, '0, 0, 0, '0, '0, 0, 32'h1234_5678);

        cyc(0, 0, '0, '0, 1, 0, 10'h001, '0, 1, 32'hA5A5_0001);
        cyc(0, 0, '0, '0, 1, 0, 10'h002, '0, 1, 32'hA5A5_0002);
        cyc(0, 0, '0, '0, 1, 0, 10'h003, '0, 1, 32'hA5A5_0003);
        idle();

        cyc(1, 0, 10'h007, '0, 0, 0, '0, '0, 0, 32'hA5A5_0007);
        idle();
        foreach (rr_exp[i]) both(rr_exp[i]);
        idle();

        // Read granted, then reset lands before its return is sampled.
        cyc(1, 0, 10'h009, '0, 0, 0, '0, '0, 0, '0, 1'b0);
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("rst_mid_read", {rv0, rv1, ram_oe, gnt0, gnt1}, 0);
        chk("rst_mid_rdata", rdata, 0);
        @(posedge clk);
        #1;
        chk("rst_hold", {rv0, ram_oe, gnt0, gnt1}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("post_rst_rvalid", {rv0, rv1, ram_oe}, 0);
        idle();
        both(0);
        idle();
        idle();

        chk("gnt_queue_drained", gnt_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
